decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 The module SHALL have port `clk`, input, 1 bit: the single clock; all outputs update on its rising edge.
REQ-002 The module SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port `Instruction`, input, 32 bits: the RV32I instruction word to decode.
REQ-004 The module SHALL have the following 1-bit outputs:
- `MemtoReg`: writeback selects memory data.
- `RegWrite`: rd is written.
- `MemWrite`: store.
- `MemRead`: load.
REQ-005 The module SHALL have port `ALUCode`, output, 4 bits: the ALU operation code.
REQ-006 The module SHALL have port `ALUSrcA`, output, 1 bit: 0 selects rs1, 1 selects PC.
REQ-007 The module SHALL have port `ALUSrcB`, output, 2 bits: 00 selects rs2, 01 selects Imm, 10 selects constant 4.
REQ-008 The module SHALL have port `Jump`, output, 1 bit: JAL.
REQ-009 The module SHALL have port `JALR`, output, 1 bit: JALR.
REQ-010 The module SHALL have port `Imm`, output, 32 bits: the sign-extended data immediate (I, S or U type).
REQ-011 The module SHALL have port `offset`, output, 32 bits: the sign-extended control-transfer offset (B, J, or I for JALR).

Function
REQ-012 All outputs SHALL be registered, with exactly 1 clock of latency from `Instruction` to outputs; there is no handshake, and a new instruction is accepted every cycle.
REQ-013 `ALUCode` SHALL use this encoding:
- add=0, sub=1, lui=2, and=3, xor=4, or=5
- sll=6, srl=7, sra=8, slt=9, sltu=10
- 11–15 reserved
REQ-014 LUI (0110111) SHALL decode as: RegWrite=1, ALUCode=lui (pass B), ALUSrcB=01, Imm={inst[31:12],12'b0}.
REQ-015 AUIPC (0010111) SHALL decode as: RegWrite=1, ALUSrcA=1, ALUSrcB=01, ALUCode=add, Imm = U-type immediate.
REQ-016 JAL (1101111) SHALL decode as:
- control: Jump=1, RegWrite=1, ALUSrcA=1, ALUSrcB=10, ALUCode=add.
- offset: sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
REQ-017 JALR (1100111) SHALL decode as:
- control: JALR=1, RegWrite=1, ALUSrcA=1, ALUSrcB=10, ALUCode=add.
- offset: sign-extended inst[31:20].
REQ-018 Branches (1100011) SHALL decode as:
- control: RegWrite=0, ALUSrcB=00, ALUCode=sub.
- offset: sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
- The branch condition itself is resolved outside this block.
REQ-019 Loads (0000011) SHALL decode as: MemRead=1, MemtoReg=1, RegWrite=1, ALUSrcB=01, ALUCode=add, Imm = I-type immediate.
REQ-020 Stores (0100011) SHALL decode as: MemWrite=1, RegWrite=0, ALUSrcB=01, ALUCode=add, Imm = sign-extended {inst[31:25],inst[11:7]}.
REQ-021 OP-IMM (0010011) SHALL decode as:
- RegWrite=1, ALUSrcB=01, Imm = I-type immediate.
- ALUCode by funct3: 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and, 001 sll.
- funct3=101 gives srl, or sra when inst[30]=1.
- For shifts, Imm = zero-extended inst[24:20].
REQ-022 OP (0110011) SHALL decode as:
- RegWrite=1, ALUSrcB=00.
- ALUCode by funct3 as in OP-IMM, except funct3=000 with inst[30]=1 gives sub.
REQ-023 For any other opcode, all control outputs SHALL be 0, ALUCode=add, and Imm=offset=0; no illegal-instruction flag is raised.
REQ-024 Fields not defined for a given opcode (Imm or offset) SHALL be 0, and unused control bits SHALL be 0.

Reset
REQ-025 While `reset`=1, all outputs SHALL be 0, asynchronously and independent of `clk`; this state is a bubble (no writes, no jumps).
REQ-026 On `reset` deassertion, the first rising edge of `clk` SHALL register the decode of the current `Instruction`; an instruction applied while reset is asserted mid-stream is discarded.

Structure
REQ-027 A shared package SHALL hold the opcode constants, the ALUCode encodings, and the ALUSrcB encodings.
REQ-028 The design SHALL contain one combinational sub-module, imm_gen (Instruction -> Imm, offset), followed by the output register stage in decode.

Verification
REQ-029 The bench SHALL cover these scenarios, each checked 1 clock after the instruction is applied:
- 32'h00003f37 (lui x30,0x3) -> RegWrite=1, ALUCode=2, ALUSrcB=01, Imm=32'h00003000.
- 32'h02000fe7 (jalr x31,32(x0)) -> JALR=1, Jump=0, RegWrite=1, ALUSrcA=1, ALUSrcB=10, offset=32'h00000020.
- 32'hfc000ae3 (beq x0,x0) -> RegWrite=0, ALUCode=1, offset=32'hffffffd4.
- 32'h001c2623 (sw) -> MemWrite=1, Imm=32'h0000000c; then 32'h00432e83 (lw) -> MemRead=1, MemtoReg=1, RegWrite=1, Imm=32'h00000004.
- 32'h406283b3 (sub) -> ALUCode=1, ALUSrcB=00; 32'h002e9293 (slli 2) -> ALUCode=6, Imm=2; 32'h00733e33 (sltu) -> ALUCode=10.
- Reset asserted mid-stream after 32'h00000f6f (jal) -> all outputs 0 immediately, without waiting for a clock edge; after release, jal decodes to Jump=1, offset=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes, ALU B-source selects.
package decode_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_LUI  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SLTU = 4'd10
   } alu_code_e;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } alu_src_b_e;

   // Maps funct3 to an ALU operation. 'alt' is inst[30]; it selects sub only for
   // register-register ops (is_reg), and selects sra over srl for both forms.
   function automatic alu_code_e alu_from_funct3(input logic [2:0] funct3,
                                                 input logic       alt,
                                                 input logic       is_reg);
      alu_code_e code;
      case (funct3)
         3'b000:  code = (is_reg && alt) ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         3'b111:  code = ALU_AND;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: data immediate (I/S/U, shamt) and
// control-transfer offset (B/J, I for JALR). Fields an opcode does not use are 0.
module imm_gen
   import decode_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [31:0] o_imm,
   output logic [31:0] o_offset
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_u;
   logic [31:0] w_off_b;
   logic [31:0] w_off_j;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign w_imm_u  = {i_instr[31:12], 12'b0};
   assign w_off_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign w_off_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   // Select the immediate and offset that the current opcode defines.
   always_comb begin
      o_imm    = 32'd0;
      o_offset = 32'd0;
      case (w_opcode)
         OPC_LUI, OPC_AUIPC: o_imm = w_imm_u;
         OPC_LOAD:           o_imm = w_imm_i;
         OPC_STORE:          o_imm = w_imm_s;
         OPC_OPIMM: begin
            // shifts carry a 5-bit shift amount, not a signed immediate
            if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
               o_imm = {27'd0, i_instr[24:20]};
            end else begin
               o_imm = w_imm_i;
            end
         end
         OPC_JAL:            o_offset = w_off_j;
         OPC_JALR:           o_offset = w_imm_i;
         OPC_BRANCH:         o_offset = w_off_b;
         default: begin
            o_imm    = 32'd0;
            o_offset = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/decode.sv
// RV32I instruction decoder: combinational control decode and immediate
// generation followed by one output register stage (1-cycle latency).
module decode
   import decode_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instruction,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        MemRead,
   output logic [3:0]  ALUCode,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic        Jump,
   output logic        JALR,
   output logic [31:0] Imm,
   output logic [31:0] offset
);

   logic [6:0]  w_opcode;
   logic        w_mem_to_reg;
   logic        w_reg_write;
   logic        w_mem_write;
   logic        w_mem_read;
   alu_code_e   w_alu_code;
   logic        w_alu_src_a;
   alu_src_b_e  w_alu_src_b;
   logic        w_jump;
   logic        w_jalr;
   logic [31:0] w_imm;
   logic [31:0] w_offset;

   logic        r_mem_to_reg;
   logic        r_reg_write;
   logic        r_mem_write;
   logic        r_mem_read;
   logic [3:0]  r_alu_code;
   logic        r_alu_src_a;
   logic [1:0]  r_alu_src_b;
   logic        r_jump;
   logic        r_jalr;
   logic [31:0] r_imm;
   logic [31:0] r_offset;

   assign w_opcode = Instruction[6:0];

   imm_gen u_imm_gen (
      .i_instr  (Instruction),
      .o_imm    (w_imm),
      .o_offset (w_offset)
   );

   // Decode control signals from the opcode; unknown opcodes decode as a bubble.
   always_comb begin
      w_mem_to_reg = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_mem_read   = 1'b0;
      w_alu_code   = ALU_ADD;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = SRCB_RS2;
      w_jump       = 1'b0;
      w_jalr       = 1'b0;
      case (w_opcode)
         OPC_LUI: begin
            w_reg_write = 1'b1;
            w_alu_code  = ALU_LUI;
            w_alu_src_b = SRCB_IMM;
         end
         OPC_AUIPC: begin
            w_reg_write = 1'b1;
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_IMM;
         end
         OPC_JAL: begin
            w_jump      = 1'b1;
            w_reg_write = 1'b1;
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_FOUR;
         end
         OPC_JALR: begin
            w_jalr      = 1'b1;
            w_reg_write = 1'b1;
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_FOUR;
         end
         OPC_BRANCH: begin
            w_alu_code  = ALU_SUB;
         end
         OPC_LOAD: begin
            w_mem_read   = 1'b1;
            w_mem_to_reg = 1'b1;
            w_reg_write  = 1'b1;
            w_alu_src_b  = SRCB_IMM;
         end
         OPC_STORE: begin
            w_mem_write = 1'b1;
            w_alu_src_b = SRCB_IMM;
         end
         OPC_OPIMM: begin
            w_reg_write = 1'b1;
            w_alu_src_b = SRCB_IMM;
            w_alu_code  = alu_from_funct3(Instruction[14:12], Instruction[30], 1'b0);
         end
         OPC_OP: begin
            w_reg_write = 1'b1;
            w_alu_code  = alu_from_funct3(Instruction[14:12], Instruction[30], 1'b1);
         end
         default: begin
            w_reg_write = 1'b0;
            w_alu_code  = ALU_ADD;
         end
      endcase
   end

   // Output register stage; reset forces an all-zero bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_to_reg <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_alu_code   <= 4'd0;
         r_alu_src_a  <= 1'b0;
         r_alu_src_b  <= 2'b00;
         r_jump       <= 1'b0;
         r_jalr       <= 1'b0;
         r_imm        <= 32'd0;
         r_offset     <= 32'd0;
      end else begin
         r_mem_to_reg <= w_mem_to_reg;
         r_reg_write  <= w_reg_write;
         r_mem_write  <= w_mem_write;
         r_mem_read   <= w_mem_read;
         r_alu_code   <= w_alu_code;
         r_alu_src_a  <= w_alu_src_a;
         r_alu_src_b  <= w_alu_src_b;
         r_jump       <= w_jump;
         r_jalr       <= w_jalr;
         r_imm        <= w_imm;
         r_offset     <= w_offset;
      end
   end

   assign MemtoReg = r_mem_to_reg;
   assign RegWrite = r_reg_write;
   assign MemWrite = r_mem_write;
   assign MemRead  = r_mem_read;
   assign ALUCode  = r_alu_code;
   assign ALUSrcA  = r_alu_src_a;
   assign ALUSrcB  = r_alu_src_b;
   assign Jump     = r_jump;
   assign JALR     = r_jalr;
   assign Imm      = r_imm;
   assign offset   = r_offset;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed instruction scenarios, reset
// behaviour, and randomized instructions against an arithmetic reference model.
module tb_decode;

   typedef struct packed {
      logic        mem_to_reg;
      logic        reg_write;
      logic        mem_write;
      logic        mem_read;
      logic [3:0]  alu_code;
      logic        alu_src_a;
      logic [1:0]  alu_src_b;
      logic        jump;
      logic        jalr;
      logic [31:0] imm;
      logic [31:0] offset;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [31:0] Instruction;
   logic        MemtoReg, RegWrite, MemWrite, MemRead;
   logic [3:0]  ALUCode;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic        Jump, JALR;
   logic [31:0] Imm, offset;

   exp_t obs;
   int   n_cmp  = 0;
   int   n_fail = 0;

   // funct3 -> ALU code (add, sll, slt, sltu, xor, srl, or, and)
   logic [3:0] alu_tab [8] = '{4'd0, 4'd6, 4'd9, 4'd10, 4'd4, 4'd7, 4'd5, 4'd3};
   logic [6:0] opc_tab [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

   decode dut (
      .clk         (clk),
      .reset       (reset),
      .Instruction (Instruction),
      .MemtoReg    (MemtoReg),
      .RegWrite    (RegWrite),
      .MemWrite    (MemWrite),
      .MemRead     (MemRead),
      .ALUCode     (ALUCode),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .Jump        (Jump),
      .JALR        (JALR),
      .Imm         (Imm),
      .offset      (offset)
   );

   assign obs = {MemtoReg, RegWrite, MemWrite, MemRead, ALUCode, ALUSrcA,
                 ALUSrcB, Jump, JALR, Imm, offset};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference decode built from the instruction-format rules with arithmetic.
   function automatic exp_t model(input logic [31:0] w);
      exp_t               e;
      logic signed [31:0] s;
      logic [31:0]        sgn, i_imm, s_imm, u_imm, b_off, j_off;
      logic [2:0]         f3;
      e     = '0;
      s     = $signed(w);
      sgn   = 32'(s >>> 31);
      f3    = w[14:12];
      i_imm = 32'(s >>> 20);
      s_imm = 32'(s >>> 25) * 32'd32 + 32'(w[11:7]);
      u_imm = w & 32'hFFFFF000;
      b_off = sgn * 32'd4096 + 32'(w[7]) * 32'd2048 + 32'(w[30:25]) * 32'd32
            + 32'(w[11:8]) * 32'd2;
      j_off = sgn * 32'h00100000 + 32'(w[19:12]) * 32'd4096 + 32'(w[20]) * 32'd2048
            + 32'(w[30:21]) * 32'd2;
      case (w[6:0])
         7'h37: begin e.reg_write = 1'b1; e.alu_code = 4'd2; e.alu_src_b = 2'b01; e.imm = u_imm; end
         7'h17: begin e.reg_write = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = 2'b01; e.imm = u_imm; end
         7'h6f: begin e.jump = 1'b1; e.reg_write = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.offset = j_off; end
         7'h67: begin e.jalr = 1'b1; e.reg_write = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.offset = i_imm; end
         7'h63: begin e.alu_code = 4'd1; e.offset = b_off; end
         7'h03: begin e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.alu_src_b = 2'b01; e.imm = i_imm; end
         7'h23: begin e.mem_write = 1'b1; e.alu_src_b = 2'b01; e.imm = s_imm; end
         7'h13: begin
            e.reg_write = 1'b1;
            e.alu_src_b = 2'b01;
            e.alu_code  = alu_tab[f3];
            if (f3 == 3'd5 && w[30]) e.alu_code = 4'd8;
            e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(w[24:20]) : i_imm;
         end
         7'h33: begin
            e.reg_write = 1'b1;
            e.alu_code  = alu_tab[f3];
            if (f3 == 3'd5 && w[30]) e.alu_code = 4'd8;
            if (f3 == 3'd0 && w[30]) e.alu_code = 4'd1;
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
      n_cmp++;
      assert (o === x) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, o, x);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t x);
      n_cmp++;
      assert (obs === x) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, x);
      end
   endtask

   // Apply an instruction, then compare the full output set one clock later.
   task automatic step(input string tag, input logic [31:0] w);
      @(negedge clk);
      Instruction = w;
      @(posedge clk);
      #1;
      chk_all(tag, model(w));
   endtask

   initial begin
      logic [31:0] rnd;
      int          k;
      reset       = 1'b1;
      Instruction = 32'h00000000;
      #2;
      chk_all("reset_state", '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      step("lui", 32'h00003f37);
      chk("lui_regwrite", 32'(RegWrite), 32'd1);
      chk("lui_alucode",  32'(ALUCode),  32'd2);
      chk("lui_srcb",     32'(ALUSrcB),  32'd1);
      chk("lui_imm",      Imm,           32'h00003000);

      step("jalr", 32'h02000fe7);
      chk("jalr_jalr",   32'(JALR),    32'd1);
      chk("jalr_jump",   32'(Jump),    32'd0);
      chk("jalr_rw",     32'(RegWrite), 32'd1);
      chk("jalr_srca",   32'(ALUSrcA), 32'd1);
      chk("jalr_srcb",   32'(ALUSrcB), 32'd2);
      chk("jalr_offset", offset,       32'h00000020);

      step("beq", 32'hfc000ae3);
      chk("beq_rw",      32'(RegWrite), 32'd0);
      chk("beq_alucode", 32'(ALUCode),  32'd1);
      chk("beq_offset",  offset,        32'hffffffd4);

      step("sw", 32'h001c2623);
      chk("sw_memwrite", 32'(MemWrite), 32'd1);
      chk("sw_imm",      Imm,           32'h0000000c);
      step("lw", 32'h00432e83);
      chk("lw_memread",  32'(MemRead),  32'd1);
      chk("lw_memtoreg", 32'(MemtoReg), 32'd1);
      chk("lw_rw",       32'(RegWrite), 32'd1);
      chk("lw_imm",      Imm,           32'h00000004);

      step("sub", 32'h406283b3);
      chk("sub_alucode", 32'(ALUCode), 32'd1);
      chk("sub_srcb",    32'(ALUSrcB), 32'd0);
      step("slli", 32'h002e9293);
      chk("slli_alucode", 32'(ALUCode), 32'd6);
      chk("slli_imm",     Imm,          32'h00000002);
      step("sltu", 32'h00733e33);
      chk("sltu_alucode", 32'(ALUCode), 32'd10);

      // boundaries: arithmetic shift immediate, negative I immediate, unknown opcode
      step("srai", 32'h4051d193);
      chk("srai_alucode", 32'(ALUCode), 32'd8);
      chk("srai_imm",     Imm,          32'h00000005);
      step("addi_neg", 32'hfff00093);
      chk("addi_neg_imm", Imm, 32'hffffffff);
      step("illegal", 32'hffffffff);
      chk_all("illegal_zero", '0);

      // asynchronous reset mid-stream after a JAL
      step("jal", 32'h00000f6f);
      chk("jal_jump", 32'(Jump), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_all("async_reset_zero", '0);
      @(negedge clk);
      Instruction = 32'h00003f37;
      @(posedge clk);
      #1;
      chk_all("reset_hold_zero", '0);
      @(negedge clk);
      Instruction = 32'h00000f6f;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("jal_after_reset_jump",   32'(Jump), 32'd1);
      chk("jal_after_reset_offset", offset,    32'h00000000);
      chk_all("jal_after_reset", model(32'h00000f6f));

      // randomized instructions, biased toward defined opcodes
      for (int i = 0; i < 300; i++) begin
         rnd = $urandom();
         k   = $urandom_range(0, 9);
         if (k < 9) rnd[6:0] = opc_tab[k];
         step("random", rnd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
